// File: rtl/zap_fetch_sched.sv
// Instruction-fetch sequencer: sequential/redirected fetch addresses, one outstanding
// I-cache access, and a 2-entry response buffer feeding the fetch stage.
module zap_fetch_sched #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic [31:0] i_pc_from_writeback,
    input  logic        i_clear_from_alu,
    input  logic [31:0] i_pc_from_alu,
    input  logic        i_clear_from_decode,
    input  logic [31:0] i_pc_from_decode,
    input  logic        i_stall,
    input  logic        i_cpsr_ff_t,
    output logic        o_req,
    output logic [31:0] o_req_addr,
    input  logic        i_ack,
    input  logic [31:0] i_rdata,
    input  logic        i_err,
    output logic        o_valid,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_ff,
    output logic        o_instr_abort,
    output logic        o_code_stall
);

    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic        r_out;
    logic        r_drop;
    logic        r_sleep;

    logic [31:0] r_fifo_data [2];
    logic [31:0] r_fifo_pc   [2];
    logic [1:0]  r_fifo_err;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_step;
    logic        w_can_start;
    logic        w_accept;
    logic        w_valid;
    logic        w_pop;

    assign w_redirect = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;

    always_comb begin
        w_target_raw = i_pc_from_decode;
        if (i_clear_from_writeback) begin
            w_target_raw = i_pc_from_writeback;
        end else if (i_clear_from_alu) begin
            w_target_raw = i_pc_from_alu;
        end
    end

    assign w_target = {w_target_raw[31:1], 1'b0};
    assign w_step   = i_cpsr_ff_t ? 32'd2 : 32'd4;

    // Counting the outstanding access keeps the buffer from ever overflowing.
    assign w_can_start = !i_reset && !r_out && !r_sleep && !w_redirect &&
                         ((32'(r_count) + 32'(r_out)) < FIFO_DEPTH);

    assign o_req      = !i_reset && (r_out || w_can_start);
    assign o_req_addr = r_out ? r_addr : r_pc;

    assign w_accept = i_ack && o_req && !r_drop && !w_redirect;
    assign w_valid  = (r_count != 2'd0);
    assign w_pop    = w_valid && !i_stall;

    assign o_valid       = w_valid;
    assign o_code_stall  = !w_valid;
    assign o_instruction = w_valid ? r_fifo_data[r_rd_ptr] : 32'h0;
    assign o_pc_ff       = w_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;
    assign o_instr_abort = w_valid & r_fifo_err[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc     <= RESET_VECTOR;
            r_addr   <= 32'h0;
            r_out    <= 1'b0;
            r_drop   <= 1'b0;
            r_sleep  <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (w_redirect) begin
            // An ack in this cycle retires the stale access; otherwise its data is dropped later.
            r_pc     <= w_target;
            r_sleep  <= 1'b0;
            r_out    <= r_out && !i_ack;
            r_drop   <= r_out && !i_ack;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_out) begin
                if (i_ack) begin
                    r_out  <= 1'b0;
                    r_drop <= 1'b0;
                end
            end else if (w_can_start) begin
                r_addr <= r_pc;
                r_pc   <= r_pc + w_step;
                r_out  <= !i_ack;
            end
            if (w_accept && i_err) begin
                r_sleep <= 1'b1;
            end
            if (w_accept) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_fifo_data[r_wr_ptr] <= i_rdata;
            r_fifo_pc[r_wr_ptr]   <= o_req_addr;
            r_fifo_err[r_wr_ptr]  <= i_err;
        end
    end

endmodule

// File: tb/tb_zap_fetch_sched.sv
// Self-checking bench for zap_fetch_sched: queue-based reference model compared every
// cycle, plus directed literal checks for the key scenarios.
module tb_zap_fetch_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr_wb, clr_alu, clr_dec;
    logic [31:0] pc_wb, pc_alu, pc_dec;
    logic        stall, thumb, ack, err;
    logic [31:0] rdata;
    logic        req, valid, abort, code_stall;
    logic [31:0] req_addr, instr, pc_ff;
    logic        err_en;
    logic [31:0] err_at;
    bit          model_on = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
    endfunction

    // Memory responds with an address-derived word; aborts only at the chosen address.
    assign rdata = word_of(req_addr);
    assign err   = err_en && (req_addr == err_at);

    zap_fetch_sched #(
        .RESET_VECTOR(32'h0000_0000),
        .FIFO_DEPTH  (2)
    ) dut (
        .i_clk                 (clk),
        .i_reset               (reset),
        .i_clear_from_writeback(clr_wb),
        .i_pc_from_writeback   (pc_wb),
        .i_clear_from_alu      (clr_alu),
        .i_pc_from_alu         (pc_alu),
        .i_clear_from_decode   (clr_dec),
        .i_pc_from_decode      (pc_dec),
        .i_stall               (stall),
        .i_cpsr_ff_t           (thumb),
        .o_req                 (req),
        .o_req_addr            (req_addr),
        .i_ack                 (ack),
        .i_rdata               (rdata),
        .i_err                 (err),
        .o_valid               (valid),
        .o_instruction         (instr),
        .o_pc_ff               (pc_ff),
        .o_instr_abort         (abort),
        .o_code_stall          (code_stall)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_out_addr;
    bit          m_out, m_drop, m_sleep;

    always @(negedge clk) begin : model
        bit          redir, start, e_req, e_valid, e_err, bad;
        logic [31:0] e_addr, tgt, step;
        entry_t      head, ent;
        if (reset) begin
            m_q.delete();
            m_pc       = 32'h0;
            m_out_addr = 32'h0;
            m_out      = 1'b0;
            m_drop     = 1'b0;
            m_sleep    = 1'b0;
        end else if (model_on) begin
            redir   = clr_wb || clr_alu || clr_dec;
            start   = !m_out && !m_sleep && (m_q.size() < 2) && !redir;
            e_req   = m_out || start;
            e_addr  = m_out ? m_out_addr : m_pc;
            e_err   = err_en && (e_addr == err_at);
            e_valid = (m_q.size() > 0);
            head    = e_valid ? m_q[0] : '0;
            bad = (req !== e_req) || (e_req && (req_addr !== e_addr)) ||
                  (valid !== e_valid) || (code_stall !== !e_valid) ||
                  (e_valid && ((instr !== head.data) || (pc_ff !== head.pc) ||
                               (abort !== head.err)));
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL cycle_model t=%0t: req=%b addr=%h valid=%b stall=%b instr=%h pc=%h abt=%b expected req=%b addr=%h valid=%b instr=%h pc=%h abt=%b",
                         $time, req, req_addr, valid, code_stall, instr, pc_ff, abort,
                         e_req, e_addr, e_valid, head.data, head.pc, head.err);
            end
            step = thumb ? 32'd2 : 32'd4;
            if (redir) begin
                tgt = clr_wb ? pc_wb : (clr_alu ? pc_alu : pc_dec);
                tgt[0] = 1'b0;
                m_q.delete();
                m_sleep = 1'b0;
                m_drop  = m_out && !ack;
                m_out   = m_out && !ack;
                m_pc    = tgt;
            end else begin
                if (e_valid && !stall) void'(m_q.pop_front());
                if (e_req && ack) begin
                    if (m_drop) begin
                        m_drop = 1'b0;
                    end else begin
                        ent = '{data: word_of(e_addr), pc: e_addr, err: e_err};
                        m_q.push_back(ent);
                        if (e_err) m_sleep = 1'b1;
                    end
                    m_out = 1'b0;
                    if (start) m_pc = m_pc + step;
                end else if (start) begin
                    m_out      = 1'b1;
                    m_out_addr = m_pc;
                    m_pc       = m_pc + step;
                end
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic litb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    logic [47:0] ack_pat;
    logic [47:0] stall_pat;

    initial begin
        reset = 1'b1;
        clr_wb = 1'b0; clr_alu = 1'b0; clr_dec = 1'b0;
        pc_wb = 32'h0; pc_alu = 32'h0; pc_dec = 32'h0;
        stall = 1'b0; thumb = 1'b0; ack = 1'b1;
        err_en = 1'b0; err_at = 32'h0;
        ack_pat   = 48'hB36D_5A9C_E71F;
        stall_pat = 48'h0C30_8421_1C06;

        @(posedge clk);
        @(negedge clk);
        litb("rst_req", req, 1'b0);
        litb("rst_valid", valid, 1'b0);
        litb("rst_code_stall", code_stall, 1'b1);
        litb("rst_abort", abort, 1'b0);
        lit("rst_instr", instr, 32'h0);
        lit("rst_pc", pc_ff, 32'h0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        model_on = 1'b1;

        // Zero-wait ARM stream.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lit("arm_addr", req_addr, 32'(4 * i));
            if (i > 0) lit("arm_head_pc", pc_ff, 32'(4 * (i - 1)));
            nc();
        end

        // Stall with the buffer filled.
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        litb("stall_req", req, 1'b0);
        litb("stall_valid", valid, 1'b1);
        lit("stall_head_pc", pc_ff, 32'h0000_000C);
        repeat (4) @(posedge clk);
        #1;
        stall = 1'b0;
        repeat (6) nc();

        // Redirect while an access is pending: its data must be dropped.
        ack = 1'b0; clr_dec = 1'b1; pc_dec = 32'h10;
        nc(); clr_dec = 1'b0;
        @(negedge clk);
        litb("drop_req", req, 1'b1);
        lit("drop_addr0", req_addr, 32'h10);
        nc(); clr_alu = 1'b1; pc_alu = 32'h200;
        @(negedge clk);
        lit("drop_addr1", req_addr, 32'h10);
        nc(); clr_alu = 1'b0;
        @(negedge clk);
        lit("drop_addr2", req_addr, 32'h10);
        litb("drop_valid", valid, 1'b0);
        nc(); ack = 1'b1;
        @(negedge clk);
        lit("drop_addr3", req_addr, 32'h10);
        nc();
        @(negedge clk);
        lit("redir_addr", req_addr, 32'h200);
        litb("redir_valid0", valid, 1'b0);
        nc();
        @(negedge clk);
        litb("redir_valid1", valid, 1'b1);
        lit("redir_pc", pc_ff, 32'h200);

        // Priority: writeback beats decode.
        nc(); clr_wb = 1'b1; pc_wb = 32'h40; clr_dec = 1'b1; pc_dec = 32'h80;
        nc(); clr_wb = 1'b0; clr_dec = 1'b0;
        @(negedge clk);
        lit("prio_addr", req_addr, 32'h40);
        nc();
        @(negedge clk);
        lit("prio_pc", pc_ff, 32'h40);

        // Abort at 0x8, then sleep until redirect.
        nc(); err_at = 32'h8; err_en = 1'b1; clr_dec = 1'b1; pc_dec = 32'h0;
        nc(); clr_dec = 1'b0;
        @(negedge clk);
        lit("abt_addr0", req_addr, 32'h0);
        nc();
        nc();
        @(negedge clk);
        lit("abt_addr8", req_addr, 32'h8);
        nc();
        @(negedge clk);
        litb("abt_sleep_req", req, 1'b0);
        lit("abt_pc", pc_ff, 32'h8);
        litb("abt_flag", abort, 1'b1);
        nc();
        @(negedge clk);
        litb("abt_empty_req", req, 1'b0);
        litb("abt_code_stall", code_stall, 1'b1);
        repeat (3) nc();
        @(negedge clk);
        litb("abt_still_asleep", req, 1'b0);
        nc(); err_en = 1'b0; clr_alu = 1'b1; pc_alu = 32'h100;
        nc(); clr_alu = 1'b0;
        @(negedge clk);
        litb("wake_req", req, 1'b1);
        lit("wake_addr", req_addr, 32'h100);

        // Thumb step with odd target.
        nc(); thumb = 1'b1; clr_dec = 1'b1; pc_dec = 32'h1003;
        nc(); clr_dec = 1'b0;
        @(negedge clk);
        lit("thumb_a0", req_addr, 32'h1002);
        nc();
        @(negedge clk);
        lit("thumb_a1", req_addr, 32'h1004);
        nc();
        @(negedge clk);
        lit("thumb_a2", req_addr, 32'h1006);

        // ARM wrap at top of address space.
        nc(); thumb = 1'b0; clr_alu = 1'b1; pc_alu = 32'hFFFF_FFF8;
        nc(); clr_alu = 1'b0;
        @(negedge clk);
        lit("wrap_a0", req_addr, 32'hFFFF_FFF8);
        nc();
        @(negedge clk);
        lit("wrap_a1", req_addr, 32'hFFFF_FFFC);
        nc();
        @(negedge clk);
        lit("wrap_a2", req_addr, 32'h0000_0000);

        // Mixed ack latency, stalls and redirects, checked by the model.
        for (int i = 0; i < 48; i++) begin
            nc();
            ack     = ack_pat[i];
            stall   = stall_pat[i];
            clr_dec = ((i % 16) == 7);
            pc_dec  = 32'h3000 + 32'(i * 8);
            thumb   = (i >= 32);
        end
        nc(); ack = 1'b1; stall = 1'b0; clr_dec = 1'b0;
        repeat (8) nc();
        @(negedge clk);
        model_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zap_fetch_sched.md
Name: zap_fetch_sched

Overview:
- Instruction-fetch sequencer between the I-cache bus and the fetch stage.
- Generates sequential fetch addresses (ARM +4, Thumb +2) and applies prioritized redirects (writeback > ALU > decode).
- Keeps at most one I-cache request outstanding and buffers returned words in a 2-entry FIFO that drives the fetch stage's i_instruction/i_valid/i_instr_abort/i_pc_ff.
- Discards stale responses after a redirect and sleeps after an instruction abort until the next redirect.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, response buffer entries; fixed at 2 (values other than 2 are unsupported).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_clear_from_writeback  in  1  redirect, highest priority.
- i_pc_from_writeback  in  32  target for writeback redirect.
- i_clear_from_alu  in  1  redirect, middle priority.
- i_pc_from_alu  in  32  target for ALU redirect.
- i_clear_from_decode  in  1  redirect, lowest priority.
- i_pc_from_decode  in  32  target for decode redirect.
- i_stall  in  1  fetch stage cannot consume this cycle (OR of downstream stalls).
- i_cpsr_ff_t  in  1  Thumb state; selects address step.
- o_req  out  1  I-cache request.
- o_req_addr  out  32  request address.
- i_ack  in  1  request complete; i_rdata/i_err valid this cycle.
- i_rdata  in  32  fetched word.
- i_err  in  1  instruction abort for this access.
- o_valid  out  1  FIFO head valid.
- o_instruction  out  32  head word.
- o_pc_ff  out  32  head address.
- o_instr_abort  out  1  head carries abort.
- o_code_stall  out  1  high when FIFO empty (no instruction available).

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_reset, synchronous and active-high.
- Reset values:
  - pc_ff=RESET_VECTOR, addr_ff=0, out_ff=0, drop_ff=0, sleep_ff=0, FIFO count=0.
  - Outputs: o_valid=0, o_instr_abort=0, o_instruction=0, o_pc_ff=0, o_req=0, o_code_stall=1.
  - Reset mid-request forgets the outstanding access; the I-cache shares i_reset.
- Address step: step = i_cpsr_ff_t ? 2 : 4. Arithmetic is 32-bit modulo, so 0xFFFF_FFFC+4 = 0.
- Request start:
  - can_start = !out_ff && !sleep_ff && (count + out_ff) < 2 && no redirect this cycle.
  - o_req = out_ff | can_start.
  - o_req_addr = out_ff ? addr_ff : pc_ff.
  - On start: addr_ff<=pc_ff, pc_ff<=pc_ff+step, out_ff<=!i_ack.
- Bus rule: once asserted, o_req and o_req_addr stay stable until i_ack. Requests are never withdrawn.
- Zero-wait ack is allowed: i_ack in the start cycle. Peak throughput is one word per cycle.
- Ack accept (i_ack && o_req && !drop_ff && no redirect):
  - Push {i_rdata, o_req_addr, i_err} to FIFO tail.
  - If i_err: sleep_ff<=1.
- Ack while drop_ff=1: data discarded, drop_ff<=0, out_ff<=0.
- Pop: o_valid && !i_stall removes the head. Push and pop in the same cycle keep count unchanged.
- The FIFO never overflows, by the can_start rule. Verification asserts count<=2.
- Redirect (any i_clear_*):
  - Select target by priority wb > alu > decode; force target[0]=0.
  - pc_ff<=target; FIFO flushed (count=0); sleep_ff<=0.
  - If out_ff=1 and no i_ack this cycle: drop_ff<=1.
  - If i_ack arrives in the redirect cycle: the data is discarded and no drop is needed.
  - The first request to the target starts the cycle after the redirect, or after the drop ack if one is pending.
- Sleep: no new requests start. The FIFO still drains. Only a redirect or reset exits sleep.
- i_stall does not affect an outstanding request. It only blocks pop and, through the FIFO count, new starts.

Test Plan:
- Reset, always-ack zero-wait, ARM: o_req_addr 0,4,8,C on consecutive cycles; o_valid from cycle 2 with o_pc_ff 0,4,8.
- i_stall high 5 cycles with FIFO full: o_req=0; head holds; on release, entries pop in order with no loss or duplicate.
- Request to 0x10 pending (no ack), i_clear_from_alu target 0x200: o_req_addr stays 0x10 until ack; that data is dropped; next o_req_addr=0x200; o_valid first shows pc 0x200.
- Same cycle: i_clear_from_writeback target 0x40 and i_clear_from_decode target 0x80: pc_ff=0x40.
- Ack with i_err=1 at 0x8: abort entry delivered with o_instr_abort=1; no further o_req until i_clear_from_alu target 0x100, then fetch resumes at 0x100.
- Thumb, i_cpsr_ff_t=1, redirect target 0x1003: fetch addresses 0x1002, 0x1004, 0x1006.
